// File: rtl/button_event_ctrl_if.sv
// button_event_ctrl_if: event valid/ready handshake plus the event-lost pulse
interface button_event_ctrl_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_repeat;
    logic       evt_lost;
    modport master(output evt_valid, evt_id, evt_repeat, evt_lost, input evt_ready);
    modport slave(input evt_valid, evt_id, evt_repeat, evt_lost, output evt_ready);
endinterface

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: debounces 4 raw buttons into press/auto-repeat events on a valid/ready port
module button_event_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 20,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 i_btn_n,
    output logic [3:0]                 o_btn_level,
    button_event_ctrl_if.master        evt
);
    localparam int DW = $clog2(TICK_DIV);
    typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, RPT, DEB_REL} state_t;
    state_t      r_st [4];
    logic [15:0] r_cnt [4];
    logic [3:0]  r_sync1, r_sync2, r_lvl, r_pend, r_prep;
    logic [DW-1:0] r_div;
    logic        r_valid, r_rep, r_lost;
    logic [1:0]  r_id;
    logic        w_tick, w_load, w_any;
    logic [1:0]  w_sel;
    logic [3:0]  w_pressed, w_ev, w_rep, w_take, w_loss, w_acc;
    assign w_pressed = ~r_sync2;
    assign w_tick    = r_div == DW'(TICK_DIV - 1);
    assign w_any     = |r_pend;
    assign w_sel     = r_pend[0] ? 2'd0 : r_pend[1] ? 2'd1 : r_pend[2] ? 2'd2 : 2'd3;
    assign w_load    = !r_valid || evt.evt_ready;
    assign w_take    = (w_load && w_any) ? 4'b0001 << w_sel : 4'b0000;
    assign w_loss    = w_ev & r_pend & ~w_take;
    assign w_acc     = w_ev & ~w_loss;
    // cnt+1==N is compared as cnt==N-1 so a full 16-bit cnt cannot wrap
    always_comb begin
        w_ev  = '0;
        w_rep = '0;
        for (int i = 0; i < 4; i++) begin
            w_ev[i]  = w_tick && w_pressed[i] &&
                       ((r_st[i] == DEB_PRESS && r_cnt[i] == 16'(STABLE_TICKS)) ||
                        (r_st[i] == HELD && r_cnt[i] == 16'(HOLD_TICKS - 1)) ||
                        (r_st[i] == RPT && r_cnt[i] == 16'(REPEAT_TICKS - 1)));
            w_rep[i] = r_st[i] != DEB_PRESS;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_div   <= '0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_div   <= w_tick ? '0 : r_div + DW'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_st[i]  <= IDLE;
                r_cnt[i] <= '0;
            end
            r_lvl <= '0;
        end else if (w_tick) begin
            for (int i = 0; i < 4; i++) begin
                case (r_st[i])
                    IDLE: if (w_pressed[i]) begin
                        r_st[i]  <= DEB_PRESS;
                        r_cnt[i] <= 16'd1;
                    end
                    DEB_PRESS: if (!w_pressed[i]) r_st[i] <= IDLE;
                    else if (r_cnt[i] == 16'(STABLE_TICKS)) begin
                        r_st[i]  <= HELD;
                        r_cnt[i] <= '0;
                        r_lvl[i] <= 1'b1;
                    end else r_cnt[i] <= r_cnt[i] + 16'd1;
                    HELD, RPT: if (!w_pressed[i]) begin
                        r_st[i]  <= DEB_REL;
                        r_cnt[i] <= 16'd1;
                    end else if (r_cnt[i] == 16'(r_st[i] == HELD ? HOLD_TICKS - 1 : REPEAT_TICKS - 1)) begin
                        r_st[i]  <= RPT;
                        r_cnt[i] <= '0;
                    end else r_cnt[i] <= r_cnt[i] + 16'd1;
                    DEB_REL: if (w_pressed[i]) begin
                        r_st[i]  <= HELD;
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] == 16'(STABLE_TICKS)) begin
                        r_st[i]  <= IDLE;
                        r_lvl[i] <= 1'b0;
                    end else r_cnt[i] <= r_cnt[i] + 16'd1;
                    default: begin
                        r_st[i]  <= IDLE;
                        r_lvl[i] <= 1'b0;
                    end
                endcase
            end
        end
    end
    // a dropped event keeps the older pend_rep; a refill in the consume cycle is not a loss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_prep  <= '0;
            r_lost  <= 1'b0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_rep   <= 1'b0;
        end else begin
            r_pend <= w_ev | (r_pend & ~w_take);
            r_prep <= (r_prep & ~w_acc) | (w_rep & w_acc);
            r_lost <= |w_loss;
            if (w_load) begin
                r_valid <= w_any;
                if (w_any) begin
                    r_id  <= w_sel;
                    r_rep <= r_prep[w_sel];
                end
            end
        end
    end
    assign evt.evt_valid  = r_valid;
    assign evt.evt_id     = r_id;
    assign evt.evt_repeat = r_rep;
    assign evt.evt_lost   = r_lost;
    assign o_btn_level    = r_lvl;
endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000; clk cycles per sample tick (1 ms at 100 MHz), legal range 2..2^20.
REQ-002 Parameter STABLE_TICKS, default 20; consecutive ticks of a stable level needed to accept a press or release, legal range 1..65535.
REQ-003 Parameter HOLD_TICKS, default 500; ticks a press is held before the first repeat event, legal range 1..65535.
REQ-004 Parameter REPEAT_TICKS, default 100; ticks between later repeat events, legal range 1..65535.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007 btn_n  input  4  raw bouncing buttons, asynchronous, idle high, low = pressed.
REQ-008 evt_valid  output  1  an event is presented on evt_id and evt_repeat.
REQ-009 evt_ready  input  1  consumer accepts the event; transfer occurs when evt_valid and evt_ready are both high on a rising edge.
REQ-010 evt_id  output  2  index of the button that produced the event.
REQ-011 evt_repeat  output  1  0 = initial press event, 1 = auto-repeat event.
REQ-012 evt_lost  output  1  one-cycle pulse when an event is dropped.
REQ-013 btn_level  output  4  debounced held level per button (1 = held).

Function
REQ-014 Each btn_n bit SHALL pass through a 2-flop synchronizer whose flops reset to 1; pressed_s[i] = inverse of the second flop.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be high for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-016 Each button SHALL have an independent FSM with states IDLE, DEB_PRESS, HELD, RPT, DEB_REL and a 16-bit tick counter cnt; the FSM and cnt change only on tick cycles.
REQ-017 IDLE: pressed_s -> DEB_PRESS with cnt=1.
REQ-018 DEB_PRESS: if not pressed_s -> IDLE. Otherwise, if cnt==STABLE_TICKS -> HELD, raise a press event, cnt=0. Otherwise cnt+1.
REQ-019 HELD: if not pressed_s -> DEB_REL with cnt=1. Otherwise, if cnt+1==HOLD_TICKS -> RPT, raise a repeat event, cnt=0. Otherwise cnt+1.
REQ-020 RPT: if not pressed_s -> DEB_REL with cnt=1. Otherwise, if cnt+1==REPEAT_TICKS -> raise a repeat event, cnt=0. Otherwise cnt+1.
REQ-021 DEB_REL: if pressed_s -> HELD with cnt=0, and no new press event is raised. Otherwise, if cnt==STABLE_TICKS -> IDLE. Otherwise cnt+1.
REQ-022 btn_level[i] SHALL be 1 in HELD, RPT and DEB_REL, and 0 otherwise; it is registered with the FSM state.
REQ-023 An event raised on tick cycle T SHALL set pending[i] and pend_rep[i] at edge T+1.
REQ-024 If pending[i] is already set and is not being consumed in the same cycle, the new event SHALL be dropped, pend_rep[i] SHALL be kept, and evt_lost SHALL pulse for one cycle.
REQ-025 Output register loading: when evt_valid is 0, or evt_valid and evt_ready are both 1, the register SHALL load the lowest-index pending button (fixed priority 0 > 1 > 2 > 3), set evt_valid, and clear that pending bit; with nothing pending, evt_valid SHALL go to 0.
REQ-026 A new event for button i arriving in the same cycle its pending bit is consumed SHALL set pending[i] again; no loss, no evt_lost.
REQ-027 While evt_valid=1 and evt_ready=0, evt_id and evt_repeat SHALL stay stable.
REQ-028 Minimum latency from the event tick to evt_valid SHALL be 2 cycles.

Reset
REQ-029 While rst_n=0: synchronizer flops = 1; prescaler, all cnt and all pending bits = 0; FSMs = IDLE; evt_valid=0, evt_id=0, evt_repeat=0, evt_lost=0, btn_level=0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight and pending events; after release, a still-held button SHALL restart from IDLE and complete full press debounce.

Verification
Bench parameters: TICK_DIV=4, STABLE_TICKS=3, HOLD_TICKS=5, REPEAT_TICKS=2.
REQ-031 Hold btn_n[2]=0 for 40 ticks, evt_ready=1 -> one event {id=2, repeat=0} after 4 ticks; first repeat 5 ticks later; further repeats every 2 ticks; btn_level[2]=1.
REQ-032 Toggle btn_n[0] every tick for 20 ticks -> no event; btn_level[0]=0 throughout.
REQ-033 Press buttons 1 and 3 together, evt_ready=1 -> events on consecutive cycles, id=1 then id=3, evt_lost=0.
REQ-034 Hold button 0 into repeat with evt_ready=0 -> first event held stable; second repeat gives evt_lost pulse; on raising evt_ready, exactly 2 events (press, repeat) delivered.
REQ-035 Release glitch of 1 tick while HELD -> returns to HELD, no new press event; clean release -> btn_level=0 after 3 stable ticks.
REQ-036 Assert rst_n=0 with evt_valid=1 and pending bits set -> all outputs 0 immediately; button still held after release -> new press event after full debounce.
